// File: rtl/timing_track_if.sv
// timing_track_if: control inputs and track outputs of the drum timing-track generator
interface timing_track_if #(parameter int ADR_BITS = 7);
    logic                run;
    logic                ld_adr;
    logic [ADR_BITS-1:0] adr_in;
    logic                z1;
    logic                z2;
    logic                z3;
    logic [5:0]          bit_no;
    logic [ADR_BITS-1:0] adr;
    logic                index;
    logic                busy;
    modport master (
        output run, ld_adr, adr_in,
        input  z1, z2, z3, bit_no, adr, index, busy
    );
    modport slave (
        input  run, ld_adr, adr_in,
        output z1, z2, z3, bit_no, adr, index, busy
    );
endinterface

// File: rtl/timing_track_gen.sv
// timing_track_gen: drum timing tracks Z1 (bit clock), Z2 (word marker) and Z3 (serial sector address)
module timing_track_gen #(
    parameter int BIT_CLKS  = 10,
    parameter int Z1_HIGH   = 2,
    parameter int WORD_BITS = 40,
    parameter int ADR_BITS  = 7
) (
    input logic           i_clk,
    input logic           i_clr,
    timing_track_if.slave io_trk
);
    localparam int CW = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] CYC_Z1   = CW'(Z1_HIGH);
    localparam logic [5:0] BIT_LAST = 6'(WORD_BITS - 1);
    localparam logic [5:0] Z2_A_LO  = 6'(WORD_BITS - 9);
    localparam logic [5:0] Z2_A_HI  = 6'(WORD_BITS - 7);
    localparam logic [5:0] Z2_B_LO  = 6'(WORD_BITS - 2);
    localparam logic [5:0] Z3_LO    = 6'(WORD_BITS - 8);
    localparam logic [5:0] Z3_HI    = 6'(WORD_BITS - 9 + ADR_BITS);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              r_state, w_state;
    logic [CW-1:0]       r_cyc, w_cyc;
    logic [5:0]          r_bit, w_bit, w_idx;
    logic [ADR_BITS-1:0] r_adr, w_adr, r_pend, w_pend, w_adr_sh;
    logic                r_pv, w_pv, w_run;
    logic                r_z1, r_z2, r_z3, r_index, r_busy;

    // Next-state: counters advance in RUN, address and pending load resolve at the word boundary
    always_comb begin
        w_state = r_state;
        w_cyc   = r_cyc;
        w_bit   = r_bit;
        w_adr   = r_adr;
        w_pend  = r_pend;
        w_pv    = r_pv;
        if (r_state == S_IDLE) begin
            w_adr   = io_trk.ld_adr ? io_trk.adr_in : r_adr;
            w_state = io_trk.run ? S_RUN : S_IDLE;
        end else if (r_cyc == CYC_LAST && r_bit == BIT_LAST) begin
            w_adr   = io_trk.ld_adr ? io_trk.adr_in : r_pv ? r_pend : r_adr + 1'b1;
            w_pv    = 1'b0;
            w_cyc   = '0;
            w_bit   = '0;
            w_state = io_trk.run ? S_RUN : S_IDLE;
        end else begin
            w_cyc  = (r_cyc == CYC_LAST) ? '0 : r_cyc + 1'b1;
            w_bit  = (r_cyc == CYC_LAST) ? r_bit + 1'b1 : r_bit;
            w_pend = io_trk.ld_adr ? io_trk.adr_in : r_pend;
            w_pv   = r_pv | io_trk.ld_adr;
        end
        w_run    = (w_state == S_RUN);
        w_idx    = w_bit - Z3_LO;
        w_adr_sh = w_adr >> w_idx;
    end

    // State and track registers; tracks are decoded from next-state so they line up with cyc/BIT
    always_ff @(posedge i_clk) begin
        if (!i_clr) begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_adr   <= '0;
            r_pend  <= '0;
            r_pv    <= 1'b0;
            r_z1    <= 1'b0;
            r_z2    <= 1'b0;
            r_z3    <= 1'b0;
            r_index <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cyc   <= w_cyc;
            r_bit   <= w_bit;
            r_adr   <= w_adr;
            r_pend  <= w_pend;
            r_pv    <= w_pv;
            r_z1    <= w_run && w_cyc < CYC_Z1;
            r_z2    <= w_run && ((w_bit >= Z2_A_LO && w_bit <= Z2_A_HI) || w_bit >= Z2_B_LO);
            r_z3    <= w_run && w_bit >= Z3_LO && w_bit <= Z3_HI && w_adr_sh[0];
            r_index <= w_run && w_adr == '0 && w_bit == '0 && w_cyc == '0;
            r_busy  <= w_run;
        end
    end

    assign io_trk.z1     = r_z1;
    assign io_trk.z2     = r_z2;
    assign io_trk.z3     = r_z3;
    assign io_trk.bit_no = r_bit;
    assign io_trk.adr    = r_adr;
    assign io_trk.index  = r_index;
    assign io_trk.busy   = r_busy;
endmodule

// File: tb/tb_timing_track_gen.sv
// tb_timing_track_gen: randomized and directed stimulus against a word-time reference model with a scoreboard
module tb_timing_track_gen;
    localparam int BC = 10;
    localparam int WB = 40;
    localparam int AB = 7;
    localparam int WL = BC * WB;

    logic clk = 1'b0;
    logic clr = 1'b0;

    timing_track_if #(.ADR_BITS(AB)) trk ();

    timing_track_gen #(
        .BIT_CLKS (BC),
        .Z1_HIGH  (2),
        .WORD_BITS(WB),
        .ADR_BITS (AB)
    ) dut (
        .i_clk (clk),
        .i_clr (clr),
        .io_trk(trk)
    );

    always #5 clk = ~clk;

    logic [17:0] exp_q[$];
    logic [17:0] e_v, a_v;
    int total = 0;
    int bad   = 0;

    bit m_run, m_pv;
    int m_t, m_adr, m_pend;

    // Model: a running word is just a time index 0..WL-1; bit and cycle derive from it by division
    task automatic tick(input logic c, input logic r, input logic l, input logic [AB-1:0] a);
        int b, cy;
        logic z3;
        @(negedge clk);
        clr = c;
        trk.run = r;
        trk.ld_adr = l;
        trk.adr_in = a;
        if (!c) begin
            m_run = 0; m_t = 0; m_adr = 0; m_pv = 0;
        end else if (!m_run) begin
            if (l) m_adr = int'(a);
            if (r) begin m_run = 1; m_t = 0; end
        end else if (m_t == WL - 1) begin
            m_adr = l ? int'(a) : m_pv ? m_pend : (m_adr + 1) % (1 << AB);
            m_pv = 0;
            m_t = 0;
            m_run = r;
        end else begin
            m_t++;
            if (l) begin m_pend = int'(a); m_pv = 1; end
        end
        b  = m_run ? m_t / BC : 0;
        cy = m_run ? m_t % BC : 0;
        z3 = m_run && b >= WB - 8 && b <= WB - 9 + AB && (((m_adr >> (b - (WB - 8))) & 1) == 1);
        exp_q.push_back({m_run && cy < 2,
                         m_run && ((b >= WB - 9 && b <= WB - 7) || b >= WB - 2),
                         z3,
                         m_run && m_adr == 0 && b == 0 && cy == 0,
                         m_run,
                         6'(b),
                         7'(m_adr)});
    endtask

    task automatic run_to(input int target);
        int n = 0;
        while (!m_run || m_t != target) begin
            if (n++ > 2 * WL) begin
                total++; bad++;
                $display("FAIL run_to timeout: got t=%0d want t=%0d", m_t, target);
                break;
            end
            tick(1, 1, 0, 0);
        end
    endtask

    task automatic stop_run();
        int n = 0;
        while (m_run) begin
            if (n++ > 2 * WL) begin
                total++; bad++;
                $display("FAIL stop timeout: got busy=1 want busy=0");
                break;
            end
            tick(1, 0, 0, 0);
        end
    endtask

    // Monitor: compare every registered output against the oldest queued expectation
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e_v = exp_q.pop_front();
            a_v = {trk.z1, trk.z2, trk.z3, trk.index, trk.busy, trk.bit_no, trk.adr};
            total++;
            if (a_v !== e_v) begin
                bad++;
                $display("FAIL outs @%0t: got z1z2z3/idx/busy=%b bit=%0d adr=%0d want %b bit=%0d adr=%0d",
                         $time, a_v[17:13], a_v[12:7], a_v[6:0], e_v[17:13], e_v[12:7], e_v[6:0]);
            end
        end
    end

    initial begin
        int n;
        trk.run = 0; trk.ld_adr = 0; trk.adr_in = '0;
        m_run = 0; m_pv = 0; m_t = 0; m_adr = 0; m_pend = 0;
        repeat (3) tick(0, 0, 0, 0);
        // one plain word from ADR=0
        tick(1, 1, 0, 0);
        repeat (WL - 1) tick(1, 1, 0, 0);
        stop_run();
        // load 0x55 while idle, send it and the following word
        tick(1, 0, 1, 7'h55);
        tick(1, 1, 0, 0);
        repeat (2 * WL - 1) tick(1, 1, 0, 0);
        stop_run();
        // 127 wraps to 0 with INDEX
        tick(1, 0, 1, 7'd127);
        tick(1, 1, 0, 0);
        repeat (WL) tick(1, 1, 0, 0);
        stop_run();
        // 127 with a load on the boundary cycle
        tick(1, 0, 1, 7'd127);
        tick(1, 1, 0, 0);
        run_to(WL - 1);
        tick(1, 1, 1, 7'd5);
        stop_run();
        // drop RUN mid-word
        tick(1, 1, 0, 0);
        run_to(12 * BC);
        tick(1, 0, 0, 0);
        stop_run();
        // reset mid-word with RUN held
        tick(1, 1, 0, 0);
        run_to(33 * BC + 4);
        tick(0, 1, 0, 0);
        repeat (20) tick(1, 1, 0, 0);
        stop_run();
        // two loads in one word, the later one wins
        tick(1, 1, 0, 0);
        run_to(20 * BC);
        tick(1, 1, 1, 7'd3);
        run_to(30 * BC);
        tick(1, 1, 1, 7'd9);
        run_to(WL - 1);
        repeat (WL) tick(1, 1, 0, 0);
        stop_run();
        // random traffic
        repeat (4000)
            tick($urandom_range(0, 499) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 29) == 0, 7'($urandom));
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (exp_q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
